// File: rtl/writeback_stage.sv
// Writeback stage: retires ALU, PC+4 and load results into the register bank, one instruction per two cycles.
// Optional macro WB_MISALIGN_TRAP_EN enables misaligned-load detection (error pulse, write suppressed).
module writeback_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rd_addr,
    input  logic        in_rd_we,
    input  logic [1:0]  in_wb_sel,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_pc,
    input  logic [2:0]  in_funct3,
    input  logic [1:0]  in_addr_lo,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic [4:0]  rd_addr,
    output logic        rd_we,
    output logic [31:0] rd_data_from_wb,
    output logic        busy,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } state_t;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    state_t      state;
    state_t      state_next;

    logic [4:0]  cap_rd;
    logic        cap_we;
    logic [2:0]  cap_funct3;
    logic [1:0]  cap_addr_lo;

    logic [4:0]  rd_addr_q;
    logic        rd_we_q;
    logic [31:0] rd_data_q;

    logic        accept;
    logic        rsp_take;
    logic [31:0] nonload_result;
    logic        nonload_we;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic        load_misaligned;
    logic        load_we;

    assign accept   = in_valid && (state == IDLE);
    assign rsp_take = mem_rsp_valid && (state == WAIT_MEM);

    assign in_ready        = (state == IDLE);
    assign busy            = (state != IDLE);
    assign rd_addr         = rd_addr_q;
    assign rd_we           = rd_we_q;
    assign rd_data_from_wb = rd_data_q;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = (in_wb_sel == SEL_LOAD) ? WAIT_MEM : WRITE;
                end
            end
            WAIT_MEM: begin
                if (mem_rsp_valid) begin
                    state_next = WRITE;
                end
            end
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Register writes to x0, instructions without a destination and the "none" source all retire silently.
    always_comb begin
        nonload_result = in_alu_result;
        if (in_wb_sel == SEL_PC4) begin
            nonload_result = in_pc + 32'd4;
        end
        nonload_we = in_rd_we && (in_rd_addr != 5'd0) && (in_wb_sel != SEL_NONE);
    end

    always_comb begin
        load_byte = mem_rsp_data[7:0];
        case (cap_addr_lo)
            2'd0: load_byte = mem_rsp_data[7:0];
            2'd1: load_byte = mem_rsp_data[15:8];
            2'd2: load_byte = mem_rsp_data[23:16];
            2'd3: load_byte = mem_rsp_data[31:24];
            default: load_byte = mem_rsp_data[7:0];
        endcase
        load_half = cap_addr_lo[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];

        load_data = mem_rsp_data;
        case (cap_funct3)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_data = {24'd0, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b101:  load_data = {16'd0, load_half};
            default: load_data = mem_rsp_data;
        endcase
    end

`ifdef WB_MISALIGN_TRAP_EN
    // Only halfword and word loads can be misaligned; unknown funct3 values behave as word loads without trapping.
    always_comb begin
        load_misaligned = 1'b0;
        case (cap_funct3)
            3'b001, 3'b101: load_misaligned = cap_addr_lo[0];
            3'b010:         load_misaligned = (cap_addr_lo != 2'd0);
            default:        load_misaligned = 1'b0;
        endcase
    end
`else
    assign load_misaligned = 1'b0;
`endif

    assign load_we = cap_we && (cap_rd != 5'd0) && !load_misaligned;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs are loaded only on entry to WRITE, so they hold their last values through IDLE and WAIT_MEM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_rd      <= 5'd0;
            cap_we      <= 1'b0;
            cap_funct3  <= 3'd0;
            cap_addr_lo <= 2'd0;
            rd_addr_q   <= 5'd0;
            rd_we_q     <= 1'b0;
            rd_data_q   <= 32'd0;
        end else begin
            rd_we_q <= 1'b0;
            if (accept) begin
                cap_rd      <= in_rd_addr;
                cap_we      <= in_rd_we;
                cap_funct3  <= in_funct3;
                cap_addr_lo <= in_addr_lo;
                if (in_wb_sel != SEL_LOAD) begin
                    rd_addr_q <= in_rd_addr;
                    rd_data_q <= nonload_result;
                    rd_we_q   <= nonload_we;
                end
            end
            if (rsp_take) begin
                rd_addr_q <= cap_rd;
                rd_data_q <= load_data;
                rd_we_q   <= load_we;
            end
        end
    end

`ifdef WB_MISALIGN_TRAP_EN
    logic misalign_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= rsp_take && load_misaligned;
        end
    end

    assign misalign_err = misalign_q;
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL have port: in_valid  input  1  upstream presents a retiring instruction.
REQ-004 SHALL have port: in_ready  output  1  stage can accept; transfer when in_valid & in_ready high at a rising edge.
REQ-005 SHALL have port: in_rd_addr  input  5  destination register.
REQ-006 SHALL have port: in_rd_we  input  1  instruction writes a register.
REQ-007 SHALL have port: in_wb_sel  input  2  source: 00 ALU, 01 load, 10 PC+4, 11 none.
REQ-008 SHALL have ports: in_alu_result  input  32; in_pc  input  32; in_funct3  input  3 (load type); in_addr_lo  input  2 (load byte offset).
REQ-009 SHALL have ports: mem_rsp_valid  input  1; mem_rsp_data  input  32  aligned data-memory read word.
REQ-010 SHALL have ports: rd_addr  output  5; rd_we  output  1; rd_data_from_wb  output  32  register bank write port.
REQ-011 SHALL have ports: busy  output  1  (state != IDLE); misalign_err  output  1  one-cycle error pulse.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT_MEM, WRITE; in_ready = 1 only in IDLE.
REQ-013 IDLE, accept with in_wb_sel != 01: SHALL capture rd/we, register result (ALU, or in_pc+4 modulo 2^32), go to WRITE.
REQ-014 IDLE, accept with in_wb_sel == 01: SHALL capture rd/we, funct3 and addr_lo, go to WAIT_MEM.
REQ-015 WAIT_MEM: SHALL stay until mem_rsp_valid = 1, then register extracted load data and go to WRITE.
REQ-016 WRITE: SHALL drive rd_we = 1 for exactly one cycle, then go to IDLE unconditionally.
REQ-017 rd_we SHALL be 0 in WRITE when captured rd = 0, captured we = 0, or wb_sel = 11; latency is unchanged.
REQ-018 rd_we SHALL be 0 in IDLE and WAIT_MEM; rd_addr and rd_data_from_wb SHALL hold their last values outside WRITE.
REQ-019 Latency: non-load accepted at edge N SHALL give rd_we high in the cycle after edge N; load SHALL give rd_we high in the cycle after the edge sampling mem_rsp_valid.
REQ-020 Load extraction: LB 000 / LBU 100 byte at addr_lo, sign/zero-extended; LH 001 / LHU 101 halfword at addr_lo[1], sign/zero-extended; LW 010 and any other funct3 full word.
REQ-021 mem_rsp_valid SHALL be ignored in IDLE and WRITE.
REQ-022 Back-to-back throughput SHALL be one instruction per two cycles (accept, WRITE).

Reset
REQ-023 reset = 0 SHALL immediately force state IDLE and clear rd_we, rd_addr, rd_data_from_wb, misalign_err, busy and all captured fields to 0.
REQ-024 Reset asserted in WAIT_MEM or WRITE SHALL abort the instruction; no write occurs after release.
REQ-025 After reset release, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-026 Macro WB_MISALIGN_TRAP_EN SHALL gate misaligned-load detection.
REQ-027 With WB_MISALIGN_TRAP_EN defined: LH/LHU with addr_lo[0] = 1, or LW with addr_lo != 0, SHALL pulse misalign_err in the WRITE cycle and force rd_we = 0.
REQ-028 Without WB_MISALIGN_TRAP_EN: misalign_err SHALL be tied 0 and extraction SHALL follow REQ-020 regardless of alignment.

Verification
REQ-029 ALU op rd=5, alu=32'h1234_5678, wb_sel=00 -> next cycle rd_we=1, rd_addr=5, data=32'h1234_5678; following cycle rd_we=0, in_ready=1.
REQ-030 LB rd=3, addr_lo=2; mem_rsp_data=32'h0080_FF00 after 3 wait cycles -> busy for 3 cycles, then rd_we=1, data=32'hFFFF_FF80; LBU same -> 32'h0000_0080.
REQ-031 PC+4 rd=1, in_pc=32'hFFFF_FFFC -> data=32'h0000_0000, rd_we=1.
REQ-032 ALU op rd=0, alu=32'hDEAD_BEEF -> WRITE cycle with rd_we=0; in_ready high again one cycle later.
REQ-033 Load accepted, reset=0 during WAIT_MEM, mem_rsp_valid after release -> no rd_we pulse, all outputs 0, in_ready=1.
REQ-034 WB_MISALIGN_TRAP_EN defined, LW addr_lo=1 -> misalign_err=1 for one cycle, rd_we=0; undefined -> rd_we=1, data=mem_rsp_data.
